qspi_packet_engine: RTL and testbench

- Byte-level protocol stage that sits between qspislave_rx/qspislave_tx and the rest of the FPGA.
- Consumes received bytes (rxready/rxdata) and parses framed commands:
  - write: stores a burst into a local byte memory;
  - read: streams memory bytes back to the transmitter (txready/txdata);
  - status: returns a status byte.
- Exposes a user-side read port and write notification so fabric logic can use the memory as a register bank.

---
 rtl/qspi_packet_engine.sv | 169 ++++++++++++++++
 tb/tb_qspi_packet_engine.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_packet_engine.sv
// Byte-level QSPI packet engine: parses WRITE/READ/STATUS packets from the receiver,
// keeps a small byte memory and feeds read/status bytes to the transmitter.
module qspi_packet_engine #(
    parameter int         AWIDTH    = 4,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              qss,
    input  logic              rxready,
    input  logic [7:0]        rxdata,
    input  logic              txready,
    output logic [7:0]        txdata,
    input  logic [AWIDTH-1:0] usr_addr,
    output logic [7:0]        usr_rdata,
    output logic              wr_strobe,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        err_count
);

    localparam int DEPTH = 2 ** AWIDTH;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_RDATA,
        ST_DISCARD
    } state_t;

    state_t            state_q;
    logic              opRead_q;
    logic [AWIDTH-1:0] ptr_q;
    logic [7:0]        cnt_q;
    logic [1:0]        qssSync_q;
    logic              qssDly_q;
    logic              statusPending_q;
    logic [7:0]        txData_q;
    logic [7:0]        usrRdata_q;
    logic              wrStrobe_q;
    logic [AWIDTH-1:0] wrAddr_q;
    logic [7:0]        wrData_q;
    logic [7:0]        errCount_q;

    logic [7:0]        mem [DEPTH];

    logic              frameEnd_d;
    logic              memWrite_d;
    logic [AWIDTH-1:0] ptrInc_d;

    assign frameEnd_d = qssSync_q[1] & ~qssDly_q;
    assign memWrite_d = rxready && (state_q == ST_WDATA);
    assign ptrInc_d   = ptr_q + AWIDTH'(1);

    always_ff @(posedge clk) begin
        if (memWrite_d) begin
            mem[ptr_q] <= rxdata;
        end
    end

    // Transmit handling first, then receive, then frame end: later assignments win,
    // so a received byte or a frame end overrides a same-cycle transmit update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= ST_CMD;
            opRead_q        <= 1'b0;
            ptr_q           <= '0;
            cnt_q           <= 8'd0;
            qssSync_q       <= 2'b11;
            qssDly_q        <= 1'b1;
            statusPending_q <= 1'b0;
            txData_q        <= IDLE_BYTE;
            usrRdata_q      <= 8'd0;
            wrStrobe_q      <= 1'b0;
            wrAddr_q        <= '0;
            wrData_q        <= 8'd0;
            errCount_q      <= 8'd0;
        end else begin
            qssSync_q  <= {qssSync_q[0], qss};
            qssDly_q   <= qssSync_q[1];
            usrRdata_q <= mem[usr_addr];
            wrStrobe_q <= 1'b0;

            if (txready) begin
                if (state_q == ST_RDATA) begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q > 8'd1) begin
                        txData_q <= mem[ptr_q];
                        ptr_q    <= ptrInc_d;
                    end else begin
                        txData_q <= IDLE_BYTE;
                        state_q  <= ST_CMD;
                    end
                end else if (statusPending_q) begin
                    txData_q        <= IDLE_BYTE;
                    statusPending_q <= 1'b0;
                end
            end

            if (rxready) begin
                unique case (state_q)
                    ST_CMD: begin
                        if (rxdata == CMD_WRITE || rxdata == CMD_READ) begin
                            opRead_q <= (rxdata == CMD_READ);
                            state_q  <= ST_ADDR;
                        end else if (rxdata == CMD_STATUS) begin
                            txData_q        <= {(errCount_q != 8'd0), 3'b000, 4'h0};
                            statusPending_q <= 1'b1;
                        end else begin
                            state_q <= ST_DISCARD;
                            if (errCount_q != 8'hFF) begin
                                errCount_q <= errCount_q + 8'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        ptr_q   <= rxdata[AWIDTH-1:0];
                        state_q <= ST_LEN;
                    end
                    ST_LEN: begin
                        cnt_q <= rxdata;
                        if (rxdata == 8'd0) begin
                            state_q <= ST_CMD;
                        end else if (opRead_q) begin
                            state_q         <= ST_RDATA;
                            txData_q        <= mem[ptr_q];
                            ptr_q           <= ptrInc_d;
                            statusPending_q <= 1'b0;
                        end else begin
                            state_q <= ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        wrStrobe_q <= 1'b1;
                        wrAddr_q   <= ptr_q;
                        wrData_q   <= rxdata;
                        ptr_q      <= ptrInc_d;
                        cnt_q      <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_q <= ST_CMD;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (frameEnd_d) begin
                state_q         <= ST_CMD;
                txData_q        <= IDLE_BYTE;
                statusPending_q <= 1'b0;
            end
        end
    end

    assign txdata    = txData_q;
    assign usr_rdata = usrRdata_q;
    assign wr_strobe = wrStrobe_q;
    assign wr_addr   = wrAddr_q;
    assign wr_data   = wrData_q;
    assign err_count = errCount_q;

endmodule

// File: tb/tb_qspi_packet_engine.sv
// Directed bench for qspi_packet_engine: expected memory writes go into a queue
// that a monitor drains on every wr_strobe; tx/user/error outputs are checked inline.
module tb_qspi_packet_engine;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          qss;
    logic          rxready;
    logic [7:0]    rxdata;
    logic          txready;
    logic [7:0]    txdata;
    logic [AW-1:0] usr_addr;
    logic [7:0]    usr_rdata;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t wrQ[$];

    always #5 clk = ~clk;

    qspi_packet_engine #(.AWIDTH(AW), .IDLE_BYTE(8'hFF)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .qss       (qss),
        .rxready   (rxready),
        .rxdata    (rxdata),
        .txready   (txready),
        .txdata    (txdata),
        .usr_addr  (usr_addr),
        .usr_rdata (usr_rdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err_count (err_count)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic withTx);
        rxdata  = b;
        rxready = 1'b1;
        txready = withTx;
        tick(1);
        rxready = 1'b0;
        txready = 1'b0;
        tick(1);
    endtask

    task automatic txPulse();
        txready = 1'b1;
        tick(1);
        txready = 1'b0;
        tick(1);
    endtask

    task automatic expectWrite(input logic [AW-1:0] a, input logic [7:0] d);
        wrQ.push_back({a, d});
    endtask

    task automatic frameEnd();
        qss = 1'b1;
        tick(4);
        qss = 1'b0;
        tick(3);
    endtask

    task automatic checkUsr(input logic [AW-1:0] a, input logic [7:0] exp);
        usr_addr = a;
        tick(1);
        checkOutput("usr_rdata", usr_rdata, exp);
    endtask

    // Every write the DUT commits must match the oldest outstanding expectation.
    initial begin
        wr_t exp;
        forever begin
            @(negedge clk);
            if (wr_strobe === 1'b1) begin
                if (wrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL wr_unexpected: got addr %h data %h expected no write", wr_addr, wr_data);
                end else begin
                    exp = wrQ.pop_front();
                    checkOutput("wr_addr", 8'(wr_addr), 8'(exp.addr));
                    checkOutput("wr_data", wr_data, exp.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn   = 1'b0;
        qss      = 1'b1;
        rxready  = 1'b0;
        rxdata   = 8'h00;
        txready  = 1'b0;
        usr_addr = '0;
        tick(3);
        checkOutput("reset_txdata", txdata, 8'hFF);
        checkOutput("reset_err", err_count, 8'h00);
        checkOutput("reset_usr", usr_rdata, 8'h00);
        checkOutput("reset_strobe", 8'(wr_strobe), 8'h00);
        resetn = 1'b1;
        tick(2);
        qss = 1'b0;
        tick(5);
        checkOutput("idle_txdata", txdata, 8'hFF);
        checkOutput("idle_err", err_count, 8'h00);

        $display("[TB] write burst");
        expectWrite(4'd5, 8'hAA);
        expectWrite(4'd6, 8'hBB);
        expectWrite(4'd7, 8'hCC);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'hCC, 1'b0);
        checkUsr(4'd6, 8'hBB);
        checkUsr(4'd5, 8'hAA);
        checkOutput("write_txdata", txdata, 8'hFF);

        $display("[TB] read with wrap");
        expectWrite(4'd15, 8'h11);
        expectWrite(4'd0, 8'h22);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'h02, 1'b0);
        checkOutput("read_hdr", txdata, 8'h11);
        txPulse();
        checkOutput("read_tx1", txdata, 8'h22);
        txPulse();
        checkOutput("read_tx2", txdata, 8'hFF);
        applyStimulus(8'h03, 1'b0);
        checkOutput("status_noerr", txdata, 8'h00);
        txPulse();
        checkOutput("status_consumed", txdata, 8'hFF);
        txPulse();
        checkOutput("idle_tx_nochange", txdata, 8'hFF);

        $display("[TB] illegal command");
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h55, 1'b0);
        checkOutput("illegal_err", err_count, 8'h01);
        frameEnd();
        expectWrite(4'd0, 8'h55);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h55, 1'b0);
        checkUsr(4'd0, 8'h55);

        $display("[TB] abort mid-write");
        expectWrite(4'd2, 8'h10);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h10, 1'b0);
        frameEnd();
        applyStimulus(8'h03, 1'b0);
        checkOutput("status_err", txdata, 8'h80);
        txPulse();
        checkOutput("status_err_consumed", txdata, 8'hFF);
        checkUsr(4'd2, 8'h10);

        $display("[TB] frame end coincident with write byte");
        expectWrite(4'd9, 8'h5A);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h09, 1'b0);
        applyStimulus(8'h05, 1'b0);
        qss = 1'b1;
        tick(2);
        rxdata  = 8'h5A;
        rxready = 1'b1;
        tick(1);
        rxready = 1'b0;
        tick(2);
        qss = 1'b0;
        tick(3);
        expectWrite(4'd10, 8'h66);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h0A, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h66, 1'b0);
        checkUsr(4'd9, 8'h5A);

        $display("[TB] simultaneous rx and tx");
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h03, 1'b0);
        checkOutput("sim_read_hdr", txdata, 8'hAA);
        applyStimulus(8'h77, 1'b1);
        checkOutput("sim_read_tx1", txdata, 8'hBB);
        txPulse();
        checkOutput("sim_read_tx2", txdata, 8'hCC);
        txPulse();
        checkOutput("sim_read_end", txdata, 8'hFF);
        applyStimulus(8'h03, 1'b0);
        checkOutput("sim_status", txdata, 8'h80);
        expectWrite(4'd8, 8'h99);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h99, 1'b1);
        checkOutput("sim_write_tx", txdata, 8'hFF);
        checkUsr(4'd8, 8'h99);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'hA5, 1'b0);
            frameEnd();
        end
        checkOutput("err_saturated", err_count, 8'hFF);

        $display("[TB] reset during read");
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h03, 1'b0);
        checkOutput("rst_read_hdr", txdata, 8'hAA);
        resetn = 1'b0;
        tick(1);
        checkOutput("rst_txdata", txdata, 8'hFF);
        checkOutput("rst_err", err_count, 8'h00);
        resetn = 1'b1;
        tick(4);
        applyStimulus(8'h03, 1'b0);
        checkOutput("rst_status", txdata, 8'h00);
        txPulse();
        checkOutput("rst_status_consumed", txdata, 8'hFF);
        checkUsr(4'd7, 8'hCC);

        tick(3);
        checkOutput("wrQ_empty", 8'(wrQ.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
